// File: rtl/dlx_store_unit.sv
// dlx_store_unit: DLX store buffer. Formats SB/SH/SW requests into word-aligned
// writes with lane-replicated data and byte enables, buffers up to DEPTH of
// them, and drains the buffer to data memory over a req/ack handshake.
// Optional build macro: DLX_ST_MISALIGN_TRAP_EN (reject misaligned SH/SW).
module dlx_store_unit #(
    parameter int DEPTH      = 2,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk2,
    input  logic        rst2,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        st_busy,
    output logic        st_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    localparam logic [2:0] OP_SB = 3'b000;
    localparam logic [2:0] OP_SH = 3'b001;
    localparam logic [2:0] OP_SW = 3'b011;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Byte enables for a store; computed in big-endian lane order, then
    // mirrored for little-endian so lane 0 maps to bits 7:0.
    function automatic logic [3:0] fmt_be(input logic [2:0] op, input logic [1:0] a);
        logic [3:0] be_big;
        be_big = 4'b0000;
        case (op)
            OP_SB:   be_big = 4'b1000 >> a;
            OP_SH:   be_big = a[1] ? 4'b0011 : 4'b1100;
            OP_SW:   be_big = 4'b1111;
            default: be_big = 4'b0000;
        endcase
        if (BIG_ENDIAN)
            return be_big;
        else
            return {be_big[0], be_big[1], be_big[2], be_big[3]};
    endfunction

    // Lane-replicated write data; replication is endian-independent.
    function automatic logic [31:0] fmt_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   rd_nxt;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic               st_err_q, st_err_d;

    logic [29:0]        fifo_addr_q  [DEPTH];
    logic [31:0]        fifo_wdata_q [DEPTH];
    logic [3:0]         fifo_be_q    [DEPTH];

    logic [29:0]        ent_addr_d;
    logic [31:0]        ent_wdata_d;
    logic [3:0]         ent_be_d;

    logic               op_legal;
    logic               misalign;
    logic               xfer;
    logic               push;
    logic               pop;

    assign op_legal = (st_op == OP_SB) || (st_op == OP_SH) || (st_op == OP_SW);

`ifdef DLX_ST_MISALIGN_TRAP_EN
    assign misalign = ((st_op == OP_SH) && st_addr[0]) ||
                      ((st_op == OP_SW) && (st_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign st_ready  = (count_q != DEPTH_C);
    assign xfer      = st_valid && st_ready;
    assign push      = xfer && op_legal && !misalign;
    assign rd_nxt    = rd_ptr_q + PTR_W'(1);

    assign mem_req   = (state_q == REQ);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign st_err    = st_err_q;
    assign st_busy   = (count_q != '0) || (state_q == REQ);

    // Format the incoming store into a buffer entry.
    always_comb begin
        ent_addr_d  = st_addr[31:2];
        ent_wdata_d = fmt_wdata(st_op, st_data);
        ent_be_d    = fmt_be(st_op, st_addr[1:0]);
    end

    // Handshake FSM, pointer/count update and output-register loading.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        st_err_d    = xfer && !(op_legal && !misalign);
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    mem_addr_d  = {fifo_addr_q[rd_ptr_q], 2'b00};
                    mem_wdata_d = fifo_wdata_q[rd_ptr_q];
                    mem_be_d    = fifo_be_q[rd_ptr_q];
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_nxt;
                    // Chain straight into the next entry to avoid an idle cycle.
                    if (count_q > ONE_C) begin
                        mem_addr_d  = {fifo_addr_q[rd_nxt], 2'b00};
                        mem_wdata_d = fifo_wdata_q[rd_nxt];
                        mem_be_d    = fifo_be_q[rd_nxt];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d = count_q + (push ? ONE_C : '0) - (pop ? ONE_C : '0);
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk2 or negedge rst2) begin
        if (!rst2) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            st_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            st_err_q    <= st_err_d;
        end
    end

    // Buffer storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk2) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= ent_addr_d;
            fifo_wdata_q[wr_ptr_q] <= ent_wdata_d;
            fifo_be_q[wr_ptr_q]    <= ent_be_d;
        end
    end

endmodule

// File: tb/tb_dlx_store_unit.sv
// tb_dlx_store_unit: directed bench for dlx_store_unit. A big-endian instance
// (dut) and a little-endian instance (dut_le) share all stimulus.
// Honours build macro DLX_ST_MISALIGN_TRAP_EN in its expectations.
module tb_dlx_store_unit;

    logic        clk2;
    logic        rst2;
    logic        st_valid;
    logic [2:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_ack;

    logic        st_ready, mem_req, st_busy, st_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        le_st_ready, le_mem_req, le_st_busy, le_st_err;
    logic [31:0] le_mem_addr, le_mem_wdata;
    logic [3:0]  le_mem_be;

    int n_chk  = 0;
    int n_fail = 0;

    dlx_store_unit #(.DEPTH(2), .BIG_ENDIAN(1'b1)) dut (
        .clk2(clk2), .rst2(rst2),
        .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .st_busy(st_busy), .st_err(st_err)
    );

    dlx_store_unit #(.DEPTH(2), .BIG_ENDIAN(1'b0)) dut_le (
        .clk2(clk2), .rst2(rst2),
        .st_valid(st_valid), .st_ready(le_st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data),
        .mem_req(le_mem_req), .mem_ack(mem_ack), .mem_addr(le_mem_addr),
        .mem_wdata(le_mem_wdata), .mem_be(le_mem_be),
        .st_busy(le_st_busy), .st_err(le_st_err)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one store with mem_ack high and follow it through a single write.
    task automatic store_expect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] ea, input logic [31:0] ew,
                                input logic [3:0] eb, input logic [3:0] ebl);
        st_valid = 1'b1; st_op = op; st_addr = a; st_data = d;
        @(posedge clk2); #1;
        st_valid = 1'b0;
        @(negedge clk2);
        chk("lat_noreq", mem_req, 1'b0);
        chk("lat_busy", st_busy, 1'b1);
        @(negedge clk2);
        chk("wr_req", mem_req, 1'b1);
        chk("wr_addr", mem_addr, ea);
        chk("wr_wdata", mem_wdata, ew);
        chk("wr_be", mem_be, eb);
        chk("le_be", le_mem_be, ebl);
        chk("le_addr", le_mem_addr, ea);
        chk("le_wdata", le_mem_wdata, ew);
        @(negedge clk2);
        chk("wr_done_req", mem_req, 1'b0);
        chk("wr_done_busy", st_busy, 1'b0);
    endtask

    // Issue one request that must be rejected.
    task automatic err_expect(input logic [2:0] op, input logic [31:0] a);
        st_valid = 1'b1; st_op = op; st_addr = a; st_data = 32'h0BAD_0BAD;
        @(posedge clk2); #1;
        st_valid = 1'b0;
        @(negedge clk2);
        chk("err_pulse", st_err, 1'b1);
        chk("err_busy", st_busy, 1'b0);
        chk("err_ready", st_ready, 1'b1);
        @(negedge clk2);
        chk("err_clear", st_err, 1'b0);
        chk("err_busy2", st_busy, 1'b0);
        chk("err_noreq", mem_req, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst2 = 1'b0; st_valid = 1'b0; st_op = 3'b000;
        st_addr = '0; st_data = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk2);
        rst2 = 1'b1;
        @(negedge clk2);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_ready", st_ready, 1'b1);
        chk("rst_busy", st_busy, 1'b0);
        chk("rst_err", st_err, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", mem_be, 4'h0);
        chk("rst_le_ready", le_st_ready, 1'b1);

        mem_ack = 1'b1;
        // Misaligned word store
`ifdef DLX_ST_MISALIGN_TRAP_EN
        err_expect(3'b011, 32'h0000_1003);
`else
        store_expect(3'b011, 32'h0000_1003, 32'hDEAD_BEEF,
                     32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 4'b1111);
`endif
        // Byte and halfword lane tests
        store_expect(3'b000, 32'h0000_0021, 32'h0000_00A5,
                     32'h0000_0020, 32'hA5A5_A5A5, 4'b0100, 4'b0010);
        store_expect(3'b000, 32'h0000_0020, 32'h1234_565A,
                     32'h0000_0020, 32'h5A5A_5A5A, 4'b1000, 4'b0001);
        store_expect(3'b000, 32'h0000_0033, 32'h0000_00C3,
                     32'h0000_0030, 32'hC3C3_C3C3, 4'b0001, 4'b1000);
        store_expect(3'b001, 32'h0000_0042, 32'h1234_5678,
                     32'h0000_0040, 32'h5678_5678, 4'b0011, 4'b1100);
        store_expect(3'b001, 32'h0000_0050, 32'hFFFF_9ABC,
                     32'h0000_0050, 32'h9ABC_9ABC, 4'b1100, 4'b0011);
        store_expect(3'b011, 32'h0000_0100, 32'hCAFE_F00D,
                     32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 4'b1111);
`ifdef DLX_ST_MISALIGN_TRAP_EN
        err_expect(3'b001, 32'h0000_0043);
`else
        store_expect(3'b001, 32'h0000_0043, 32'h0000_BEEF,
                     32'h0000_0040, 32'hBEEF_BEEF, 4'b0011, 4'b1100);
`endif
        // Illegal opcodes
        err_expect(3'b010, 32'h0000_0000);
        err_expect(3'b111, 32'h0000_0008);

        // Backpressure: three stores with mem_ack low, DEPTH=2
        mem_ack = 1'b0;
        @(posedge clk2); #1;
        st_valid = 1'b1; st_op = 3'b011; st_addr = 32'h200; st_data = 32'h1111_1111;
        @(posedge clk2); #1;
        st_addr = 32'h204; st_data = 32'h2222_2222;
        @(posedge clk2); #1;
        st_addr = 32'h208; st_data = 32'h3333_3333;
        @(negedge clk2);
        chk("bp_ready_low", st_ready, 1'b0);
        chk("bp_req", mem_req, 1'b1);
        chk("bp_addr", mem_addr, 32'h200);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk2);
            chk("bp_hold_req", mem_req, 1'b1);
            chk("bp_hold_addr", mem_addr, 32'h200);
            chk("bp_hold_wdata", mem_wdata, 32'h1111_1111);
            chk("bp_hold_be", mem_be, 4'b1111);
            chk("bp_hold_ready", st_ready, 1'b0);
        end
        mem_ack = 1'b1;
        @(negedge clk2);
        chk("dr_b2b_req", mem_req, 1'b1);
        chk("dr_b_addr", mem_addr, 32'h204);
        chk("dr_b_wdata", mem_wdata, 32'h2222_2222);
        chk("dr_ready", st_ready, 1'b1);
        @(posedge clk2); #1;
        st_valid = 1'b0;
        @(negedge clk2);
        chk("dr_gap_req", mem_req, 1'b0);
        chk("dr_gap_busy", st_busy, 1'b1);
        @(negedge clk2);
        chk("dr_c_req", mem_req, 1'b1);
        chk("dr_c_addr", mem_addr, 32'h208);
        chk("dr_c_wdata", mem_wdata, 32'h3333_3333);
        @(negedge clk2);
        chk("dr_end_req", mem_req, 1'b0);
        chk("dr_end_busy", st_busy, 1'b0);

        // Reset while a write is outstanding with two entries buffered
        mem_ack = 1'b0;
        @(posedge clk2); #1;
        st_valid = 1'b1; st_op = 3'b011; st_addr = 32'h300; st_data = 32'h4444_4444;
        @(posedge clk2); #1;
        st_addr = 32'h304; st_data = 32'h5555_5555;
        @(posedge clk2); #1;
        st_valid = 1'b0;
        @(negedge clk2);
        chk("mr_req_pre", mem_req, 1'b1);
        chk("mr_ready_pre", st_ready, 1'b0);
        #2;
        rst2 = 1'b0;
        #1;
        chk("mr_req_async", mem_req, 1'b0);
        chk("mr_busy_async", st_busy, 1'b0);
        chk("mr_le_req_async", le_mem_req, 1'b0);
        @(negedge clk2);
        rst2 = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk2);
            chk("mr_noreq", mem_req, 1'b0);
            chk("mr_busy", st_busy, 1'b0);
            chk("mr_ready", st_ready, 1'b1);
            chk("mr_err", st_err, 1'b0);
        end
        chk("mr_le_busy", le_st_busy, 1'b0);
        chk("mr_le_err", le_st_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
